// File: rtl/prng_d2_feed.sv
// Fresh-mask source for the second-order threshold PRINCE S-box: 80-bit LFSR, 54 steps per word.
// Optional repetition health check compiled in with `define PRNG_D2_HEALTH_EN.
module prng_d2_feed #(
  parameter int unsigned WARMUP_CYCLES = 4,
  parameter logic [79:0] SEED_FIX      = 80'hACE1_0F0F_3C3C_5A5A_9669
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [79:0] seed_in,
  input  logic        seed_valid,
  output logic        seed_ready,
  output logic [53:0] rnd_out,
  output logic        rnd_valid,
  input  logic        rnd_ready,
  output logic        busy,
  output logic        health_err
);

  localparam int unsigned SW        = 80;
  localparam int unsigned RW        = 54;
  localparam int unsigned CW        = 8;
  localparam int unsigned ADV_STEPS = 54;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEED   = 2'd1,
    WARMUP = 2'd2,
    RUN    = 2'd3
  } state_e;

  state_e        state_q;
  logic [SW-1:0] lfsr_q;
  logic [SW-1:0] lfsr_adv;
  logic [SW-1:0] seed_fixed;
  logic [CW-1:0] cnt_q;
  logic          seed_take;
  logic          rnd_take;
  logic          health_hit;

  // 54 single Fibonacci steps unrolled into one combinational advance
  function automatic logic [SW-1:0] advance(input logic [SW-1:0] s);
    logic [SW-1:0] v;
    v = s;
    for (int i = 0; i < int'(ADV_STEPS); i++) begin
      v = {v[SW-2:0], v[79] ^ v[78] ^ v[42] ^ v[41]};
    end
    return v;
  endfunction

  assign lfsr_adv   = advance(lfsr_q);
  assign seed_fixed = (seed_in == '0) ? SEED_FIX : seed_in;
  assign seed_take  = seed_valid && seed_ready;
  assign rnd_take   = rnd_valid && rnd_ready;

`ifdef PRNG_D2_HEALTH_EN
  // rnd_out holds the word being delivered; a repeat of it in the next word is a fault
  assign health_hit = (state_q == RUN) && rnd_take && (lfsr_adv[RW-1:0] == rnd_out);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      health_err <= 1'b0;
    end else if (seed_take || state_q == SEED) begin
      health_err <= 1'b0;
    end else if (health_hit) begin
      health_err <= 1'b1;
    end
  end
`else
  assign health_hit = 1'b0;
  assign health_err = 1'b0;
`endif

  // Seeding / warm-up / run sequencer with registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lfsr_q     <= '0;
      cnt_q      <= '0;
      rnd_out    <= '0;
      rnd_valid  <= 1'b0;
      seed_ready <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          seed_ready <= 1'b1;
          busy       <= 1'b0;
          if (seed_take) begin
            lfsr_q     <= seed_fixed;
            cnt_q      <= CW'(WARMUP_CYCLES);
            state_q    <= WARMUP;
            seed_ready <= 1'b0;
            busy       <= 1'b1;
          end
        end
        SEED: begin
          rnd_valid  <= 1'b0;
          seed_ready <= 1'b0;
          busy       <= 1'b1;
          state_q    <= WARMUP;
        end
        WARMUP: begin
          lfsr_q <= lfsr_adv;
          if (cnt_q <= CW'(1)) begin
            cnt_q      <= '0;
            rnd_out    <= lfsr_adv[RW-1:0];
            rnd_valid  <= 1'b1;
            seed_ready <= 1'b1;
            busy       <= 1'b0;
            state_q    <= RUN;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        RUN: begin
          seed_ready <= 1'b1;
          busy       <= 1'b0;
          if (rnd_take) begin
            lfsr_q    <= lfsr_adv;
            rnd_out   <= lfsr_adv[RW-1:0];
            rnd_valid <= !health_hit;
          end
          // a reseed overrides the advance; the word on rnd_out was still consumed
          if (seed_take) begin
            lfsr_q     <= seed_fixed;
            cnt_q      <= CW'(WARMUP_CYCLES);
            rnd_valid  <= 1'b0;
            seed_ready <= 1'b0;
            busy       <= 1'b1;
            state_q    <= SEED;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prng_d2_feed.sv
// Directed self-checking bench for prng_d2_feed against a bit-level LFSR reference.
`timescale 1ns/1ps
module tb_prng_d2_feed;

  localparam logic [79:0] SEED_FIX = 80'hACE1_0F0F_3C3C_5A5A_9669;
  localparam logic [79:0] SEED_A   = 80'h0000_0000_0000_0000_0001;
  localparam logic [79:0] SEED_B   = 80'h1234_5678_9ABC_DEF0_1357;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [79:0] seed_in = '0;
  logic        seed_valid = 1'b0;
  logic        seed_ready;
  logic [53:0] rnd_out;
  logic        rnd_valid;
  logic        rnd_ready = 1'b0;
  logic        busy;
  logic        health_err;

  int          n_chk = 0;
  int          n_err = 0;
  logic [79:0] m;

  prng_d2_feed dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seed_in    (seed_in),
    .seed_valid (seed_valid),
    .seed_ready (seed_ready),
    .rnd_out    (rnd_out),
    .rnd_valid  (rnd_valid),
    .rnd_ready  (rnd_ready),
    .busy       (busy),
    .health_err (health_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // n advances of 54 single steps each
  function automatic logic [79:0] ref_adv(input logic [79:0] s, input int n);
    logic [79:0] v;
    v = s;
    for (int k = 0; k < n * 54; k++) v = {v[78:0], v[79] ^ v[78] ^ v[42] ^ v[41]};
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic seed_load(input logic [79:0] s);
    seed_in    = s;
    seed_valid = 1'b1;
    step();
    seed_valid = 1'b0;
  endtask

  // count cycles with rnd_valid low after a seed load, then check the first word
  task automatic wait_first(input string tag, input int exp_lat, input logic [79:0] s);
    int lat;
    lat = 0;
    while (!rnd_valid && lat < 40) begin
      lat++;
      step();
    end
    chk({tag, " latency"}, 80'(lat), 80'(exp_lat));
    m = ref_adv((s == '0) ? SEED_FIX : s, 4);
    chk({tag, " first word"}, 80'(rnd_out), 80'(m[53:0]));
  endtask

  task automatic stream(input string tag, input int n);
    logic [53:0] prev;
    rnd_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      prev = rnd_out;
      step();
      m = ref_adv(m, 1);
      chk({tag, " word"}, 80'(rnd_out), 80'(m[53:0]));
      chk({tag, " repeat"}, 80'(rnd_out == prev), 80'(0));
      chk({tag, " zero state"}, 80'(dut.lfsr_q == '0), 80'(0));
    end
    rnd_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bc;
    #1 rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      seed_valid = 1'($urandom);
      rnd_ready  = 1'($urandom);
      seed_in    = 80'({$urandom, $urandom, $urandom});
      step();
    end
    chk("rst rnd_out", 80'(rnd_out), 80'(0));
    chk("rst rnd_valid", 80'(rnd_valid), 80'(0));
    chk("rst seed_ready", 80'(seed_ready), 80'(0));
    chk("rst busy", 80'(busy), 80'(0));
    chk("rst health_err", 80'(health_err), 80'(0));
    seed_valid = 1'b0;
    rnd_ready  = 1'b0;
    rst_n      = 1'b1;
    step();
    chk("idle seed_ready", 80'(seed_ready), 80'(1));
    chk("idle busy", 80'(busy), 80'(0));

    // seed 1 from IDLE, consumer stalled
    seed_load(SEED_A);
    chk("warm seed_ready", 80'(seed_ready), 80'(0));
    bc = 0;
    while (busy && bc < 40) begin
      bc++;
      step();
    end
    chk("busy cycles", 80'(bc), 80'(4));
    chk("first valid", 80'(rnd_valid), 80'(1));
    m = ref_adv(SEED_A, 4);
    chk("first word", 80'(rnd_out), 80'(m[53:0]));
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall hold word", 80'(rnd_out), 80'(m[53:0]));
      chk("stall hold valid", 80'(rnd_valid), 80'(1));
    end

    stream("stream", 1000);

    // reseed together with a transfer
    rnd_ready  = 1'b1;
    seed_load(SEED_B);
    chk("reseed valid drop", 80'(rnd_valid), 80'(0));
    chk("reseed busy", 80'(busy), 80'(1));
    wait_first("reseed", 5, SEED_B);
    stream("reseed stream", 10);

    // all-zero seed gets substituted
    seed_load(80'(0));
    chk("zero seed state", dut.lfsr_q, SEED_FIX);
    wait_first("zero seed", 5, 80'(0));
    stream("zero stream", 5);

    // asynchronous reset between clock edges
    rnd_ready = 1'b1;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("async rnd_out", 80'(rnd_out), 80'(0));
    chk("async rnd_valid", 80'(rnd_valid), 80'(0));
    chk("async seed_ready", 80'(seed_ready), 80'(0));
    chk("async busy", 80'(busy), 80'(0));
    step();
    step();
    rst_n     = 1'b1;
    rnd_ready = 1'b0;
    step();
    chk("post rst seed_ready", 80'(seed_ready), 80'(1));
    seed_load(SEED_B);
    wait_first("reseed after rst", 4, SEED_B);
    stream("repeat stream", 10);
    chk("health_err idle", 80'(health_err), 80'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
